// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: response encodings, default data width and
// the slave-select type used by the response multiplexer.
package ahb_pkg;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int AHB_DATA_WIDTH = 32;

  // Index of one of the four slaves (0..3 selects slave 1..4).
  typedef logic [1:0] ahb_slv_sel_t;

endpackage

// File: rtl/ahb_resp_mux_if.sv
// Bus bundle between the four slaves, the decoder and the master for the
// AHB-Lite response multiplexer.
//
// Handshake: the transfer in its data phase completes on a rising edge where
// hreadyout=1. A new address-phase sel is accepted only on such an edge;
// while hreadyout=0 the data phase stays bound to the stalled slave.
//
// Modports: slave = the multiplexer's view, master = the view of whoever
// drives the slaves/decoder and consumes the response.
interface ahb_resp_mux_if
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = AHB_DATA_WIDTH
);

  ahb_slv_sel_t          sel;
  logic [DATA_WIDTH-1:0] hrdata_1;
  logic [DATA_WIDTH-1:0] hrdata_2;
  logic [DATA_WIDTH-1:0] hrdata_3;
  logic [DATA_WIDTH-1:0] hrdata_4;
  logic                  hreadyout_1;
  logic                  hreadyout_2;
  logic                  hreadyout_3;
  logic                  hreadyout_4;
  logic                  hresp_1;
  logic                  hresp_2;
  logic                  hresp_3;
  logic                  hresp_4;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyout;
  logic                  hresp;

  modport slave (
    input  sel,
    input  hrdata_1, hrdata_2, hrdata_3, hrdata_4,
    input  hreadyout_1, hreadyout_2, hreadyout_3, hreadyout_4,
    input  hresp_1, hresp_2, hresp_3, hresp_4,
    output hrdata, hreadyout, hresp
  );

  modport master (
    output sel,
    output hrdata_1, hrdata_2, hrdata_3, hrdata_4,
    output hreadyout_1, hreadyout_2, hreadyout_3, hreadyout_4,
    output hresp_1, hresp_2, hresp_3, hresp_4,
    input  hrdata, hreadyout, hresp
  );

endinterface

// File: rtl/ahb_resp_mux_sel_reg.sv
// Data-phase slave-select register. Captures the decoder's address-phase
// select whenever the bus is ready, holds it through wait states.
module ahb_resp_mux_sel_reg
  import ahb_pkg::*;
#(
  parameter ahb_slv_sel_t SEL_RESET = 2'b00
) (
  input  logic         hclk,
  input  logic         hresetn,
  input  ahb_slv_sel_t sel,
  input  logic         hready,
  output ahb_slv_sel_t sel_q
);

  // Reset wins; otherwise advance to the next data phase only on a ready edge.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      sel_q <= SEL_RESET;
    end else if (hready) begin
      sel_q <= sel;
    end
  end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite response multiplexer for four slaves. The decoder's select is
// registered at the end of the address phase and steers the selected
// slave's hrdata/hreadyout/hresp to the master during the data phase.
//
// Optional build macro AHB_RESP_MUX_RDATA_GATE_EN: when defined, hrdata is
// driven to zero while the selected slave is inserting wait states.
//
// sel_q_dbg exposes the data-phase select for observation.
module ahb_resp_mux
  import ahb_pkg::*;
#(
  parameter int           DATA_WIDTH = AHB_DATA_WIDTH,
  parameter ahb_slv_sel_t SEL_RESET  = 2'b00
) (
  input  logic         hclk,
  input  logic         hresetn,
  ahb_resp_mux_if.slave bus,
  output ahb_slv_sel_t sel_q_dbg
);

  ahb_slv_sel_t          sel_q;
  logic [DATA_WIDTH-1:0] mux_rdata;
  logic                  mux_ready;
  logic                  mux_resp;

  ahb_resp_mux_sel_reg #(
    .SEL_RESET (SEL_RESET)
  ) u_sel_reg (
    .hclk    (hclk),
    .hresetn (hresetn),
    .sel     (bus.sel),
    .hready  (bus.hreadyout),
    .sel_q   (sel_q)
  );

  assign sel_q_dbg = sel_q;

  // Pick the data-phase slave; all four encodings map to a real slave.
  always_comb begin
    mux_rdata = bus.hrdata_1;
    mux_ready = bus.hreadyout_1;
    mux_resp  = bus.hresp_1;
    case (sel_q)
      2'd0: begin
        mux_rdata = bus.hrdata_1;
        mux_ready = bus.hreadyout_1;
        mux_resp  = bus.hresp_1;
      end
      2'd1: begin
        mux_rdata = bus.hrdata_2;
        mux_ready = bus.hreadyout_2;
        mux_resp  = bus.hresp_2;
      end
      2'd2: begin
        mux_rdata = bus.hrdata_3;
        mux_ready = bus.hreadyout_3;
        mux_resp  = bus.hresp_3;
      end
      default: begin
        mux_rdata = bus.hrdata_4;
        mux_ready = bus.hreadyout_4;
        mux_resp  = bus.hresp_4;
      end
    endcase
  end

  // Drive the master side; during reset present an idle, ready, OKAY bus.
  always_comb begin
    bus.hrdata    = mux_rdata;
    bus.hreadyout = mux_ready;
    bus.hresp     = mux_resp;
`ifdef AHB_RESP_MUX_RDATA_GATE_EN
    if (!mux_ready) begin
      bus.hrdata = '0;
    end
`endif
    if (!hresetn) begin
      bus.hrdata    = '0;
      bus.hreadyout = 1'b1;
      bus.hresp     = HRESP_OKAY;
    end
  end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: directed scenarios followed by a
// randomized run compared against a slave-indexed reference model.
module tb_ahb_resp_mux;
  import ahb_pkg::*;

  localparam int           DW        = 32;
  localparam ahb_slv_sel_t SEL_RST   = 2'b00;

`ifdef AHB_RESP_MUX_RDATA_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic         hclk;
  logic         hresetn;
  ahb_slv_sel_t sel_q_dbg;

  // Stimulus state: one entry per slave, index 0..3 = slave 1..4.
  logic [DW-1:0] rd  [4];
  logic          rdy [4];
  logic          rsp [4];
  ahb_slv_sel_t  sel_drv;

  int checks;
  int fails;

  // Reference model: which slave owns the current data phase.
  int m_slv;

  ahb_resp_mux_if #(.DATA_WIDTH(DW)) bus ();

  assign bus.sel         = sel_drv;
  assign bus.hrdata_1    = rd[0];
  assign bus.hrdata_2    = rd[1];
  assign bus.hrdata_3    = rd[2];
  assign bus.hrdata_4    = rd[3];
  assign bus.hreadyout_1 = rdy[0];
  assign bus.hreadyout_2 = rdy[1];
  assign bus.hreadyout_3 = rdy[2];
  assign bus.hreadyout_4 = rdy[3];
  assign bus.hresp_1     = rsp[0];
  assign bus.hresp_2     = rsp[1];
  assign bus.hresp_3     = rsp[2];
  assign bus.hresp_4     = rsp[3];

  ahb_resp_mux #(
    .DATA_WIDTH (DW),
    .SEL_RESET  (SEL_RST)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .bus       (bus),
    .sel_q_dbg (sel_q_dbg)
  );

  // Clock / reset block.
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Model update at each edge: reset reloads; a ready slave releases the
  // bus and the address-phase sel becomes the new owner.
  always @(posedge hclk) begin
    if (!hresetn) m_slv = int'(SEL_RST);
    else if (rdy[m_slv]) m_slv = int'(sel_drv);
  end

  function automatic logic [DW-1:0] exp_rdata();
    if (!hresetn) return '0;
    if (GATE && !rdy[m_slv]) return '0;
    return rd[m_slv];
  endfunction

  function automatic logic exp_ready();
    if (!hresetn) return 1'b1;
    return rdy[m_slv];
  endfunction

  function automatic logic exp_resp();
    if (!hresetn) return 1'b0;
    return rsp[m_slv];
  endfunction

  // Driver tasks: advance to just after the next edge / let logic settle.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rd[i] = DW'(i + 1); rdy[i] = 1'b1; rsp[i] = 1'b1;
    end
    sel_drv = 2'd0;
    hresetn = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.hrdata !== 32'd0 || bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
      fails++;
      $display("FAIL reset_forced: hrdata=%0h hreadyout=%b hresp=%b expected 0/1/0",
               bus.hrdata, bus.hreadyout, bus.hresp);
    end
    hresetn = 1'b1;
    settle();
    checks++;
    if (bus.hrdata !== 32'd1 || bus.hresp !== 1'b1 || sel_q_dbg !== 2'd0) begin
      fails++;
      $display("FAIL reset_release: hrdata=%0h hresp=%b sel_q=%0d expected 1/1/0",
               bus.hrdata, bus.hresp, sel_q_dbg);
    end
  endtask

  task automatic test_sweep();
    for (int s = 0; s < 4; s++) begin
      sel_drv = ahb_slv_sel_t'(s);
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++;
        if (bus.hrdata !== DW'(s + 1) || bus.hreadyout !== 1'b1 || bus.hresp !== 1'b1) begin
          fails++;
          $display("FAIL sweep_sel%0d_cyc%0d: hrdata=%0h hreadyout=%b hresp=%b expected %0h/1/1",
                   s, c, bus.hrdata, bus.hreadyout, bus.hresp, s + 1);
        end
      end
    end
  endtask

  task automatic test_wait_state();
    logic [DW-1:0] wait_data;
    wait_data = GATE ? 32'd0 : 32'd2;
    sel_drv = 2'd1;
    tick();
    rdy[1]  = 1'b0;
    sel_drv = 2'd3;
    settle();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.hrdata !== wait_data || bus.hreadyout !== 1'b0 || sel_q_dbg !== 2'd1) begin
        fails++;
        $display("FAIL wait_hold_cyc%0d: hrdata=%0h hreadyout=%b sel_q=%0d expected %0h/0/1",
                 c, bus.hrdata, bus.hreadyout, sel_q_dbg, wait_data);
      end
      tick();
    end
    rdy[1] = 1'b1;
    settle();
    checks++;
    if (bus.hrdata !== 32'd2 || bus.hreadyout !== 1'b1) begin
      fails++;
      $display("FAIL wait_release: hrdata=%0h hreadyout=%b expected 2/1",
               bus.hrdata, bus.hreadyout);
    end
    tick();
    checks++;
    if (bus.hrdata !== 32'd4 || sel_q_dbg !== 2'd3) begin
      fails++;
      $display("FAIL wait_next: hrdata=%0h sel_q=%0d expected 4/3", bus.hrdata, sel_q_dbg);
    end
  endtask

  task automatic test_error_passthrough();
    sel_drv = 2'd2;
    tick();
    rsp[2] = 1'b0;
    settle();
    checks++;
    if (bus.hresp !== 1'b0 || bus.hrdata !== 32'd3) begin
      fails++;
      $display("FAIL err_okay: hresp=%b hrdata=%0h expected 0/3", bus.hresp, bus.hrdata);
    end
    rsp[2] = 1'b1;
    settle();
    checks++;
    if (bus.hresp !== 1'b1 || bus.hrdata !== 32'd3) begin
      fails++;
      $display("FAIL err_error: hresp=%b hrdata=%0h expected 1/3", bus.hresp, bus.hrdata);
    end
  endtask

  task automatic test_reset_mid_wait();
    sel_drv = 2'd3;
    tick();
    rdy[3] = 1'b0;
    settle();
    checks++;
    if (bus.hreadyout !== 1'b0 || sel_q_dbg !== 2'd3) begin
      fails++;
      $display("FAIL midwait_stall: hreadyout=%b sel_q=%0d expected 0/3", bus.hreadyout, sel_q_dbg);
    end
    hresetn = 1'b0;
    settle();
    checks++;
    if (bus.hrdata !== 32'd0 || bus.hreadyout !== 1'b1 || bus.hresp !== 1'b0) begin
      fails++;
      $display("FAIL midwait_forced: hrdata=%0h hreadyout=%b hresp=%b expected 0/1/0",
               bus.hrdata, bus.hreadyout, bus.hresp);
    end
    tick();
    hresetn = 1'b1;
    settle();
    checks++;
    if (sel_q_dbg !== 2'd0 || bus.hrdata !== 32'd1) begin
      fails++;
      $display("FAIL midwait_release: sel_q=%0d hrdata=%0h expected 0/1", sel_q_dbg, bus.hrdata);
    end
    rdy[3] = 1'b1;
  endtask

`ifdef AHB_RESP_MUX_RDATA_GATE_EN
  task automatic test_rdata_gate();
    sel_drv = 2'd0;
    tick();
    rdy[0] = 1'b0;
    settle();
    checks++;
    if (bus.hrdata !== 32'd0 || bus.hreadyout !== 1'b0) begin
      fails++;
      $display("FAIL gate_wait: hrdata=%0h hreadyout=%b expected 0/0", bus.hrdata, bus.hreadyout);
    end
    rdy[0] = 1'b1;
    settle();
    checks++;
    if (bus.hrdata !== 32'd1 || bus.hreadyout !== 1'b1) begin
      fails++;
      $display("FAIL gate_ready: hrdata=%0h hreadyout=%b expected 1/1", bus.hrdata, bus.hreadyout);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      sel_drv = ahb_slv_sel_t'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) begin
        rd[i]  = $urandom;
        rdy[i] = ($urandom_range(0, 3) != 0);
        rsp[i] = ($urandom_range(0, 4) == 0);
      end
      hresetn = ($urandom_range(0, 29) != 0);
      settle();
      checks++;
      if (bus.hrdata !== exp_rdata() || bus.hreadyout !== exp_ready() ||
          bus.hresp !== exp_resp()) begin
        fails++;
        $display("FAIL random_cyc%0d: got %0h/%b/%b expected %0h/%b/%b (slave %0d)",
                 c, bus.hrdata, bus.hreadyout, bus.hresp,
                 exp_rdata(), exp_ready(), exp_resp(), m_slv + 1);
      end
      checks++;
      if (int'(sel_q_dbg) != m_slv) begin
        fails++;
        $display("FAIL random_sel_q_cyc%0d: got %0d expected %0d", c, sel_q_dbg, m_slv);
      end
      tick();
    end
    hresetn = 1'b1;
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    m_slv   = int'(SEL_RST);
    hresetn = 1'b0;
    sel_drv = 2'd0;
    for (int i = 0; i < 4; i++) begin
      rd[i] = '0; rdy[i] = 1'b1; rsp[i] = 1'b0;
    end
    test_reset();
    test_sweep();
    test_wait_state();
    test_error_passthrough();
    test_reset_mid_wait();
`ifdef AHB_RESP_MUX_RDATA_GATE_EN
    test_rdata_gate();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux.md
Name: ahb_resp_mux

Overview:
- AHB-Lite slave-to-master response multiplexer for a 4-slave system. It sits between the slaves and the master, next to the address decoder.
- It routes one slave's read data, ready and response signals back to the master.
- The slave select from the decoder is captured during the address phase and applied during the data phase, so responses align with AHB pipelining.

Parameters:
- DATA_WIDTH, 32, width of hrdata buses.
- SEL_RESET, 2'b00, slave index loaded into the data-phase select register on reset.

Ports:
- hclk  input  1  bus clock; all state updates on the rising edge.
- hresetn  input  1  synchronous active-low reset.
- sel  input  2  address-phase slave select from the decoder (0..3 → slave 1..4).
- hrdata_1..hrdata_4  input  DATA_WIDTH  read data from slaves 1..4.
- hreadyout_1..hreadyout_4  input  1  ready from slaves 1..4.
- hresp_1..hresp_4  input  1  response from slaves 1..4 (0 = OKAY, 1 = ERROR).
- hrdata  output  DATA_WIDTH  selected slave read data to master.
- hreadyout  output  1  selected slave ready; this is the bus HREADY.
- hresp  output  1  selected slave response.

Behaviour:
- One register, sel_q[1:0], holds the data-phase select.
- Reset: if hresetn=0 at a rising edge, sel_q <= SEL_RESET.
- While hresetn=0, outputs are forced combinationally regardless of inputs: hrdata=0, hreadyout=1, hresp=0.
- Capture: at a rising edge with hresetn=1 and hreadyout=1 (the mux's own output), sel_q <= sel. This gives 1-cycle latency from sel to outputs.
- Hold: with hreadyout=0 (wait state), sel_q holds. The data phase stays bound to the stalled slave even if sel changes.
- Output mux, purely combinational from sel_q and slave inputs, no extra register stage:
  - sel_q=0 → slave 1 signals
  - sel_q=1 → slave 2 signals
  - sel_q=2 → slave 3 signals
  - sel_q=3 → slave 4 signals
- Slave input changes propagate to outputs in the same cycle.
- All four encodings are valid; there is no default-slave case.
- Reset mid-wait-state: sel_q returns to SEL_RESET at the next edge and outputs are forced as above. The stalled transfer is abandoned.
- Simultaneous sel change and hreadyout rising: the capture uses the values present at the edge, so the new sel is taken.
- No X-propagation masking; sel must be known whenever hreadyout=1 at an edge.

Optional Feature:
- Macro AHB_RESP_MUX_RDATA_GATE_EN.
- When defined: hrdata is driven to 0 whenever the selected hreadyout=0 (wait states never expose stale data). hreadyout and hresp are unaffected.
- When undefined: hrdata always passes the selected slave's data.

Decomposition:
- Shared package ahb_pkg:
  - HRESP_OKAY=1'b0, HRESP_ERROR=1'b1
  - AHB_DATA_WIDTH=32
  - typedef ahb_slv_sel_t (2-bit)
- One natural sub-module: ahb_resp_mux_sel_reg. It contains the sel_q register with hready-qualified capture and reset.
- The combinational 4:1 mux stays in the top level.

Test Plan:
- Reset: hresetn=0 for 2 edges with hrdata_1..4=1,2,3,4, all hreadyout_x=1, all hresp_x=1.
  - During reset: hrdata=0, hreadyout=1, hresp=0.
  - After release: hrdata=1, hresp=1.
- Sweep: sel=0,1,2,3, each held 2 cycles, all slaves ready.
  - One edge after each change: hrdata=1,2,3,4 respectively; hreadyout=1; hresp=1.
- Wait state: select slave 2, then hreadyout_2=0 and sel=3 for 3 cycles.
  - hrdata stays 2 and hreadyout=0.
  - After hreadyout_2=1, the next edge gives hrdata=4.
- Error passthrough: sel_q=2, toggle hresp_3 0→1.
  - hresp follows in the same cycle with no edge needed; hrdata=3.
- Reset mid-wait: slave 4 stalled (hreadyout_4=0), then hresetn=0 for one edge.
  - Outputs forced immediately.
  - After release: sel_q=0 and hrdata=1.
- With AHB_RESP_MUX_RDATA_GATE_EN: selected hreadyout_x=0 → hrdata=0; on ready → data reappears.
